// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for io_bus_arbiter: FSM state encoding, bus widths,
// timeout abort data and the default timeout length.
package io_bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int ARB_NMST = 2;
    localparam int ARB_DW   = 32;
    localparam int ARB_BEW  = 4;

    localparam logic [ARB_DW-1:0] ARB_TIMEOUT_DATA    = 32'hDEADBEEF;
    localparam int                ARB_DEFAULT_TIMEOUT = 16;

    // Index of the granted master in a one-hot two-master grant.
    function automatic logic gnt_index(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and io_controller.
// master/slave modports are the views of the requesters and of io_controller.
interface io_bus_arbiter_if
    import io_bus_arbiter_pkg::*;
();

    logic [ARB_NMST-1:0]         MDREQ;
    logic [ARB_NMST-1:0]         MWR;
    logic [ARB_NMST-1:0]         MRD;
    logic [ARB_NMST*ARB_BEW-1:0] MBE;
    logic [ARB_NMST*ARB_DW-1:0]  MADDR;
    logic [ARB_NMST*ARB_DW-1:0]  MDATAI;
    logic [ARB_DW-1:0]           MDATAO;
    logic [ARB_NMST-1:0]         MDACK;
    logic [ARB_NMST-1:0]         GNT;

    logic                        XDREQ;
    logic                        XWR;
    logic                        XRD;
    logic [ARB_BEW-1:0]          XBE;
    logic [ARB_DW-1:0]           XADDR;
    logic [ARB_DW-1:0]           XATAI;
    logic [ARB_DW-1:0]           XATAO;
    logic                        XDACK;

    modport master (
        output MDREQ, MWR, MRD, MBE, MADDR, MDATAI,
        input  MDATAO, MDACK, GNT
    );

    modport slave (
        input  XDREQ, XWR, XRD, XBE, XADDR, XATAI,
        output XATAO, XDACK
    );

    modport arb (
        input  MDREQ, MWR, MRD, MBE, MADDR, MDATAI, XATAO, XDACK,
        output MDATAO, MDACK, GNT, XDREQ, XWR, XRD, XBE, XADDR, XATAI
    );

endinterface

// File: rtl/io_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master that was
// not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter in front of io_controller, one transfer in flight.
// Define ARB_TIMEOUT_EN to abort a transfer after TIMEOUT cycles without XDACK.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NMST = ARB_NMST
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = ARB_DEFAULT_TIMEOUT
`endif
) (
    input logic           CLK,
    input logic           RES,
    io_bus_arbiter_if.arb bus
);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    arb_state_t      state_q, state_d;
    logic [NMST-1:0] gnt_q, gnt_d, pick;
    logic            last_q, last_d;
    logic            req_g, ack, withdraw, tmo;

    rr_pick2 u_pick (
        .req  (bus.MDREQ),
        .last (last_q),
        .gnt  (pick)
    );

    // gnt_q is zero outside XFER, so the AND-OR mux also zeroes the slave side in IDLE.
    always_comb begin
        req_g     = |(bus.MDREQ & gnt_q);
        bus.XWR   = |(bus.MWR & gnt_q);
        bus.XRD   = |(bus.MRD & gnt_q);
        bus.XBE   = ({ARB_BEW{gnt_q[0]}} & bus.MBE[ARB_BEW-1:0])
                  | ({ARB_BEW{gnt_q[1]}} & bus.MBE[2*ARB_BEW-1:ARB_BEW]);
        bus.XADDR = ({ARB_DW{gnt_q[0]}} & bus.MADDR[ARB_DW-1:0])
                  | ({ARB_DW{gnt_q[1]}} & bus.MADDR[2*ARB_DW-1:ARB_DW]);
        bus.XATAI = ({ARB_DW{gnt_q[0]}} & bus.MDATAI[ARB_DW-1:0])
                  | ({ARB_DW{gnt_q[1]}} & bus.MDATAI[2*ARB_DW-1:ARB_DW]);
    end

    assign bus.GNT = gnt_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        ack        = 1'b0;
        withdraw   = 1'b0;
        tmo        = 1'b0;
        bus.XDREQ  = 1'b0;
        bus.MDACK  = '0;
        bus.MDATAO = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.MDREQ) begin
                    gnt_d   = pick;
                    state_d = XFER;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            XFER: begin
`ifdef ARB_TIMEOUT_EN
                tmo = req_g && (cnt_q == CW'(TIMEOUT - 1));
`endif
                withdraw  = !req_g;
                // XDREQ must not depend on XDACK: io_controller acks combinationally.
                bus.XDREQ = req_g && !tmo;
                ack       = req_g && !tmo && bus.XDACK;
                if (ack) begin
                    bus.MDACK  = gnt_q;
                    bus.MDATAO = bus.XATAO;
                end else if (tmo) begin
                    bus.MDACK  = gnt_q;
                    bus.MDATAO = ARB_TIMEOUT_DATA;
                end
                if (ack || withdraw || tmo) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = gnt_index(gnt_q);
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // LAST resets to 1 so that master 0 wins the first tie.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
